multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  FSM controller that sequences the shared datapath (RF, ALU, data memory, PC) over several cycles per
//  instruction, replacing the single-cycle decoder. Decodes the same opcodes and drives the same select lines,
//  plus IR load, memory-wait sequencing and an end-of-instruction pulse. Sits between the IR and the datapath.
// PARAMETERS
//  MEM_LAT  1  data-memory access cycles (>=1); controller stays in MEM state exactly MEM_LAT cycles
// PORTS
//  Clk            in   1  clock; all state changes on rising edge
//  Reset          in   1  synchronous, active-high reset
//  Instr          in   32 IR output; valid from DEC onward, opcode = Instr[31:26], ALU func = Instr[3:0]
//  Zero           in   1  ALU zero flag, sampled combinationally in BR state
//  IR_LdEn        out  1  load IR from instruction memory
//  PC_LdEn        out  1  update PC
//  PC_Sel         out  1  0 = PC+4, 1 = PC+4+offset
//  RF_WrEn        out  1  register-file write
//  RF_WrData_sel  out  1  1 = ALU result, 0 = memory data
//  RF_B_sel       out  1  1 = rd used as second read port (I-type/mem/branch)
//  ALU_Bin_sel    out  1  1 = immediate, 0 = register
//  ALU_func       out  4  ALU operation
//  Mem_WrEn       out  1  data-memory write strobe
//  Byte_Op        out  1  1 for lb/sb (byte trim/merge in mem stage)
//  Instr_Done     out  1  one-cycle pulse in the last cycle of each instruction
//  Illegal        out  1  one-cycle pulse in DEC on an undefined opcode
// BEHAVIOUR
//  States: S_RST, S_IF, S_DEC, S_EX, S_BR, S_MEM, S_WB.
//  Reset high (any state, any cycle): next state S_RST, wait_cnt=0; all outputs forced 0 combinationally in that
//   cycle, so no RF/Mem/PC write occurs in a reset cycle. S_RST -> S_IF unconditionally.
//  S_IF: IR_LdEn=1 -> S_DEC.
//  S_DEC: classify opcode:
//   R-type 100000, addi 110000, andi 110010, ori 110011, li 111000, lw 001111, lb 000011, sw 011111,
//   sb 000111 -> S_EX; beq 000000, bne 000001 -> S_BR;
//   b 111111 -> PC_LdEn=1, PC_Sel=1, Instr_Done=1 -> S_IF;
//   other -> Illegal=1, PC_LdEn=1, PC_Sel=0, Instr_Done=1 -> S_IF (treated as NOP).
//  S_EX: ALU computes; lw/lb/sw/sb -> S_MEM, others -> S_WB.
//  S_MEM: wait_cnt counts 0..MEM_LAT-1; Mem_WrEn=1 only when wait_cnt==0 and opcode is sw/sb.
//   At wait_cnt==MEM_LAT-1: wait_cnt<=0; lw/lb -> S_WB; sw/sb -> PC_LdEn=1, Instr_Done=1 -> S_IF.
//  S_WB: RF_WrEn=1, PC_LdEn=1, PC_Sel=0, Instr_Done=1 -> S_IF.
//  S_BR: ALU_func=1 (sub); PC_LdEn=1; PC_Sel = Zero (beq) or ~Zero (bne); Instr_Done=1 -> S_IF.
//  Select lines (RF_B_sel, ALU_Bin_sel, ALU_func, RF_WrData_sel, Byte_Op) decoded from Instr in S_DEC..end,
//   held stable throughout; 0 in S_RST/S_IF:
//   R-type: B_sel 0, Bin 0, func Instr[3:0], WrData 1. addi/li: 1,1,0,1. andi: 1,1,2,1. ori: 1,1,3,1.
//   lw/lb: 1,1,0,0 (Byte_Op=1 for lb). sw/sb: 1,1,0,0 (Byte_Op=1 for sb). beq/bne: 1,0,1,0.
//  PC_LdEn asserted exactly once per instruction, in its last cycle; IR_LdEn only in S_IF.
//  Latency (cycles incl. IF): R/I-type 4; lw/lb 4+MEM_LAT; sw/sb 3+MEM_LAT; beq/bne 3; b 2; illegal 2.
//  Reset mid-MEM aborts the access: a pending store that has not yet strobed never strobes.
// TESTING
//  Reset 3 cycles then R-type add (func 0) -> IF,DEC,EX,WB; RF_WrEn=1,PC_LdEn=1 only in cycle 4; ALU_func=0.
//  lw with MEM_LAT=3 -> S_MEM held 3 cycles, RF_WrEn+Instr_Done in cycle 7, RF_WrData_sel=0 throughout.
//  sb, MEM_LAT=2 -> Mem_WrEn exactly 1 cycle (cycle 4), Byte_Op=1, no RF_WrEn, Instr_Done cycle 5.
//  beq with Zero=1 -> PC_Sel=1 in cycle 3; bne with Zero=1 -> PC_Sel=0; ALU_func=1 in both.
//  Opcode 101010 -> Illegal pulse in DEC, PC_LdEn=1 PC_Sel=0, back to IF next cycle.
//  Reset asserted in first S_MEM cycle of sw -> Mem_WrEn=0 that cycle, S_RST, then S_IF.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: walks each instruction through IF/DEC/EX/MEM/WB/BR
// and drives the shared datapath selects, IR/PC load strobes and the memory write strobe.
module multicycle_control #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        IR_LdEn,
  output logic        PC_LdEn,
  output logic        PC_Sel,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_WrEn,
  output logic        Byte_Op,
  output logic        Instr_Done,
  output logic        Illegal
);

  typedef enum logic [2:0] {
    S_RST, S_IF, S_DEC, S_EX, S_BR, S_MEM, S_WB
  } state_t;

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t           state, nextState;
  logic [CNT_W-1:0] waitCnt, nextWaitCnt;

  logic [5:0] opcode;
  logic isR, isAddi, isAndi, isOri, isLi, isLw, isLb, isSw, isSb, isBeq, isBne, isB;
  logic isLoad, isStore, isExec, isBranch;
  logic unusedInstrBits;

  assign opcode          = Instr[31:26];
  assign unusedInstrBits = ^Instr[25:4];

  assign isR      = (opcode == 6'b100000);
  assign isAddi   = (opcode == 6'b110000);
  assign isAndi   = (opcode == 6'b110010);
  assign isOri    = (opcode == 6'b110011);
  assign isLi     = (opcode == 6'b111000);
  assign isLw     = (opcode == 6'b001111);
  assign isLb     = (opcode == 6'b000011);
  assign isSw     = (opcode == 6'b011111);
  assign isSb     = (opcode == 6'b000111);
  assign isBeq    = (opcode == 6'b000000);
  assign isBne    = (opcode == 6'b000001);
  assign isB      = (opcode == 6'b111111);
  assign isLoad   = isLw | isLb;
  assign isStore  = isSw | isSb;
  assign isBranch = isBeq | isBne;
  assign isExec   = isR | isAddi | isAndi | isOri | isLi | isLoad | isStore;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= S_RST;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  always_comb begin
    nextState     = state;
    nextWaitCnt   = waitCnt;
    IR_LdEn       = 1'b0;
    PC_LdEn       = 1'b0;
    PC_Sel        = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = '0;
    Mem_WrEn      = 1'b0;
    Byte_Op       = 1'b0;
    Instr_Done    = 1'b0;
    Illegal       = 1'b0;

    // Selects follow the IR from DEC to the end of the instruction so the datapath sees them stable.
    if (state != S_RST && state != S_IF) begin
      if (isR) begin
        ALU_func      = Instr[3:0];
        RF_WrData_sel = 1'b1;
      end else if (isAddi || isLi || isAndi || isOri) begin
        RF_B_sel      = 1'b1;
        ALU_Bin_sel   = 1'b1;
        RF_WrData_sel = 1'b1;
        ALU_func      = isAndi ? 4'd2 : (isOri ? 4'd3 : 4'd0);
      end else if (isLoad || isStore) begin
        RF_B_sel    = 1'b1;
        ALU_Bin_sel = 1'b1;
        Byte_Op     = isLb | isSb;
      end else if (isBranch) begin
        RF_B_sel = 1'b1;
        ALU_func = 4'd1;
      end
    end

    unique case (state)
      S_RST: nextState = S_IF;
      S_IF: begin
        IR_LdEn   = 1'b1;
        nextState = S_DEC;
      end
      S_DEC: begin
        if (isExec) begin
          nextState = S_EX;
        end else if (isBranch) begin
          nextState = S_BR;
        end else begin
          PC_LdEn    = 1'b1;
          PC_Sel     = isB;
          Instr_Done = 1'b1;
          Illegal    = ~isB;
          nextState  = S_IF;
        end
      end
      S_EX: nextState = (isLoad || isStore) ? S_MEM : S_WB;
      S_MEM: begin
        Mem_WrEn = isStore && (waitCnt == '0);
        if (waitCnt == CNT_LAST) begin
          nextWaitCnt = '0;
          if (isLoad) begin
            nextState = S_WB;
          end else begin
            PC_LdEn    = 1'b1;
            Instr_Done = 1'b1;
            nextState  = S_IF;
          end
        end else begin
          nextWaitCnt = waitCnt + 1'b1;
        end
      end
      S_WB: begin
        RF_WrEn    = 1'b1;
        PC_LdEn    = 1'b1;
        Instr_Done = 1'b1;
        nextState  = S_IF;
      end
      S_BR: begin
        ALU_func   = 4'd1;
        PC_LdEn    = 1'b1;
        PC_Sel     = isBeq ? Zero : ~Zero;
        Instr_Done = 1'b1;
        nextState  = S_IF;
      end
      default: nextState = S_RST;
    endcase

    // Reset overrides everything so no write side effect can escape in a reset cycle.
    if (Reset) begin
      nextState     = S_RST;
      nextWaitCnt   = '0;
      IR_LdEn       = 1'b0;
      PC_LdEn       = 1'b0;
      PC_Sel        = 1'b0;
      RF_WrEn       = 1'b0;
      RF_WrData_sel = 1'b0;
      RF_B_sel      = 1'b0;
      ALU_Bin_sel   = 1'b0;
      ALU_func      = '0;
      Mem_WrEn      = 1'b0;
      Byte_Op       = 1'b0;
      Instr_Done    = 1'b0;
      Illegal       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instance A uses MEM_LAT=3, instance B uses MEM_LAT=2.
module tb_multicycle_control;

  logic        Clk;
  logic        ResetA, ZeroA, ResetB, ZeroB;
  logic [31:0] InstrA, InstrB;
  logic        IrA, PclA, PcsA, RfwA, WdA, BsA, BinA, MwA, BoA, DnA, IlA;
  logic        IrB, PclB, PcsB, RfwB, WdB, BsB, BinB, MwB, BoB, DnB, IlB;
  logic [3:0]  FnA, FnB;
  logic [14:0] obsA, obsB;
  int          checks = 0;
  int          fails  = 0;

  localparam logic [31:0] ADD  = {6'b100000, 26'h0000000};
  localparam logic [31:0] SUBA = {6'b100000, 22'h0ABCD, 4'hA};
  localparam logic [31:0] ORI  = {6'b110011, 26'h0123456};
  localparam logic [31:0] LW   = {6'b001111, 26'h0000010};
  localparam logic [31:0] LB   = {6'b000011, 26'h0000011};
  localparam logic [31:0] SW   = {6'b011111, 26'h0000020};
  localparam logic [31:0] SB   = {6'b000111, 26'h0000021};
  localparam logic [31:0] BEQ  = {6'b000000, 26'h0000004};
  localparam logic [31:0] BNE  = {6'b000001, 26'h0000004};
  localparam logic [31:0] BJ   = {6'b111111, 26'h0000008};
  localparam logic [31:0] ILL  = {6'b101010, 26'h0000000};

  multicycle_control #(.MEM_LAT(3)) dutA (
    .Clk(Clk), .Reset(ResetA), .Instr(InstrA), .Zero(ZeroA),
    .IR_LdEn(IrA), .PC_LdEn(PclA), .PC_Sel(PcsA), .RF_WrEn(RfwA),
    .RF_WrData_sel(WdA), .RF_B_sel(BsA), .ALU_Bin_sel(BinA), .ALU_func(FnA),
    .Mem_WrEn(MwA), .Byte_Op(BoA), .Instr_Done(DnA), .Illegal(IlA)
  );

  multicycle_control #(.MEM_LAT(2)) dutB (
    .Clk(Clk), .Reset(ResetB), .Instr(InstrB), .Zero(ZeroB),
    .IR_LdEn(IrB), .PC_LdEn(PclB), .PC_Sel(PcsB), .RF_WrEn(RfwB),
    .RF_WrData_sel(WdB), .RF_B_sel(BsB), .ALU_Bin_sel(BinB), .ALU_func(FnB),
    .Mem_WrEn(MwB), .Byte_Op(BoB), .Instr_Done(DnB), .Illegal(IlB)
  );

  assign obsA = {IrA, PclA, PcsA, RfwA, WdA, BsA, BinA, FnA, MwA, BoA, DnA, IlA};
  assign obsB = {IrB, PclB, PcsB, RfwB, WdB, BsB, BinB, FnB, MwB, BoB, DnB, IlB};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Field order: IR_LdEn, PC_LdEn, PC_Sel, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
  // ALU_func, Mem_WrEn, Byte_Op, Instr_Done, Illegal.
  function automatic logic [14:0] ov(input logic ir, pcl, pcs, rfw, wd, bs, bin,
                                     input logic [3:0] fn, input logic mw, bo, dn, il);
    return {ir, pcl, pcs, rfw, wd, bs, bin, fn, mw, bo, dn, il};
  endfunction

  localparam logic [14:0] FETCH = 15'b100_0000_0000_0000;

  task automatic test_reset();
    ResetA = 1'b1; ResetB = 1'b1;
    InstrA = SW; InstrB = SW; ZeroA = 1'b0; ZeroB = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      checks++;
      if (obsA !== 15'd0) begin $display("FAIL reset_hold cycle %0d: got %b want 0", c, obsA); fails++; end
    end
    ResetA = 1'b0; ResetB = 1'b0;
    #1;
    checks++;
    if (obsA !== 15'd0) begin $display("FAIL reset_rst_state: got %b want 0", obsA); fails++; end
    checks++;
    if (obsB !== 15'd0) begin $display("FAIL reset_rst_state_B: got %b want 0", obsB); fails++; end
    @(posedge Clk); #1;
  endtask

  task automatic test_rtype();
    logic [31:0] ins [2];
    logic [3:0]  fn  [2];
    logic [14:0] exp [4];
    ins[0] = ADD;  fn[0] = 4'h0;
    ins[1] = SUBA; fn[1] = 4'hA;
    for (int k = 0; k < 2; k++) begin
      exp[0] = FETCH;
      exp[1] = ov(0,0,0,0,1,0,0,fn[k],0,0,0,0);
      exp[2] = exp[1];
      exp[3] = ov(0,1,0,1,1,0,0,fn[k],0,0,1,0);
      for (int c = 0; c < 4; c++) begin
        if (c == 0) InstrA = ins[k];
        #1;
        checks++;
        if (obsA !== exp[c]) begin
          $display("FAIL rtype[%0d] cycle %0d: got %b want %b", k, c + 1, obsA, exp[c]); fails++;
        end
        @(posedge Clk); #1;
      end
    end
  endtask

  task automatic test_itype();
    logic [14:0] exp [4];
    exp[0] = FETCH;
    exp[1] = ov(0,0,0,0,1,1,1,4'd3,0,0,0,0);
    exp[2] = exp[1];
    exp[3] = ov(0,1,0,1,1,1,1,4'd3,0,0,1,0);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) InstrA = ORI;
      #1;
      checks++;
      if (obsA !== exp[c]) begin $display("FAIL ori cycle %0d: got %b want %b", c + 1, obsA, exp[c]); fails++; end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_load();
    logic [31:0] ins [2];
    logic        bo  [2];
    logic [14:0] exp [7];
    ins[0] = LW; bo[0] = 1'b0;
    ins[1] = LB; bo[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp[0] = FETCH;
      for (int c = 1; c < 6; c++) exp[c] = ov(0,0,0,0,0,1,1,4'd0,0,bo[k],0,0);
      exp[6] = ov(0,1,0,1,0,1,1,4'd0,0,bo[k],1,0);
      for (int c = 0; c < 7; c++) begin
        if (c == 0) InstrA = ins[k];
        #1;
        checks++;
        if (obsA !== exp[c]) begin
          $display("FAIL load[%0d] cycle %0d: got %b want %b", k, c + 1, obsA, exp[c]); fails++;
        end
        @(posedge Clk); #1;
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [4];
    logic        z   [4];
    logic        pcs [4];
    logic [14:0] exp [3];
    ins[0] = BEQ; z[0] = 1'b1; pcs[0] = 1'b1;
    ins[1] = BNE; z[1] = 1'b1; pcs[1] = 1'b0;
    ins[2] = BEQ; z[2] = 1'b0; pcs[2] = 1'b0;
    ins[3] = BNE; z[3] = 1'b0; pcs[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp[0] = FETCH;
      exp[1] = ov(0,0,0,0,0,1,0,4'd1,0,0,0,0);
      exp[2] = ov(0,1,pcs[k],0,0,1,0,4'd1,0,0,1,0);
      for (int c = 0; c < 3; c++) begin
        if (c == 0) begin InstrA = ins[k]; ZeroA = z[k]; end
        #1;
        checks++;
        if (obsA !== exp[c]) begin
          $display("FAIL branch[%0d] cycle %0d: got %b want %b", k, c + 1, obsA, exp[c]); fails++;
        end
        @(posedge Clk); #1;
      end
    end
    ZeroA = 1'b0;
  endtask

  task automatic test_jump_illegal();
    logic [31:0] ins [2];
    logic [14:0] exp [2][2];
    ins[0] = BJ;  exp[0][0] = FETCH; exp[0][1] = ov(0,1,1,0,0,0,0,4'd0,0,0,1,0);
    ins[1] = ILL; exp[1][0] = FETCH; exp[1][1] = ov(0,1,0,0,0,0,0,4'd0,0,0,1,1);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (c == 0) InstrA = ins[k];
        #1;
        checks++;
        if (obsA !== exp[k][c]) begin
          $display("FAIL jump_illegal[%0d] cycle %0d: got %b want %b", k, c + 1, obsA, exp[k][c]); fails++;
        end
        @(posedge Clk); #1;
      end
    end
    checks++;
    if (obsA !== FETCH) begin $display("FAIL illegal_back_to_if: got %b want %b", obsA, FETCH); fails++; end
  endtask

  task automatic test_reset_mid_mem();
    logic [14:0] exp [7];
    // Abort sw in MEM cycle 1, then a full sw; then abort in MEM cycle 2 and run a full lw.
    for (int pass = 0; pass < 2; pass++) begin
      InstrA = SW;
      for (int c = 0; c < 3 + pass; c++) begin @(posedge Clk); #1; end
      ResetA = 1'b1;
      #1;
      checks++;
      if (obsA !== 15'd0) begin $display("FAIL mem_abort[%0d]: got %b want 0", pass, obsA); fails++; end
      @(posedge Clk); #1;
      ResetA = 1'b0;
      #1;
      checks++;
      if (obsA !== 15'd0) begin $display("FAIL mem_abort_rst[%0d]: got %b want 0", pass, obsA); fails++; end
      @(posedge Clk); #1;
      if (pass == 0) begin
        exp[0] = FETCH;
        exp[1] = ov(0,0,0,0,0,1,1,4'd0,0,0,0,0);
        exp[2] = exp[1];
        exp[3] = ov(0,0,0,0,0,1,1,4'd0,1,0,0,0);
        exp[4] = exp[1];
        exp[5] = ov(0,1,0,0,0,1,1,4'd0,0,0,1,0);
        for (int c = 0; c < 6; c++) begin
          if (c == 0) InstrA = SW;
          #1;
          checks++;
          if (obsA !== exp[c]) begin
            $display("FAIL sw_after_abort cycle %0d: got %b want %b", c + 1, obsA, exp[c]); fails++;
          end
          @(posedge Clk); #1;
        end
      end else begin
        exp[0] = FETCH;
        for (int c = 1; c < 6; c++) exp[c] = ov(0,0,0,0,0,1,1,4'd0,0,0,0,0);
        exp[6] = ov(0,1,0,1,0,1,1,4'd0,0,0,1,0);
        for (int c = 0; c < 7; c++) begin
          if (c == 0) InstrA = LW;
          #1;
          checks++;
          if (obsA !== exp[c]) begin
            $display("FAIL lw_after_abort cycle %0d: got %b want %b", c + 1, obsA, exp[c]); fails++;
          end
          @(posedge Clk); #1;
        end
      end
    end
  endtask

  task automatic test_store_lat2();
    logic [14:0] exp [6];
    ResetB = 1'b1;
    @(posedge Clk); #1;
    ResetB = 1'b0;
    @(posedge Clk); #1;
    exp[0] = FETCH;
    exp[1] = ov(0,0,0,0,0,1,1,4'd0,0,1,0,0);
    exp[2] = exp[1];
    exp[3] = ov(0,0,0,0,0,1,1,4'd0,1,1,0,0);
    exp[4] = ov(0,1,0,0,0,1,1,4'd0,0,1,1,0);
    exp[5] = FETCH;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) InstrB = SB;
      #1;
      checks++;
      if (obsB !== exp[c]) begin $display("FAIL sb_lat2 cycle %0d: got %b want %b", c + 1, obsB, exp[c]); fails++; end
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_load();
    test_branch();
    test_jump_illegal();
    test_reset_mid_mem();
    test_store_lat2();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
